imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. It covers all base RISC-V immediate formats (I, S, B, U, J) plus an optional CSR zero-extended immediate, and sign-extends to a configurable XLEN. The result is registered behind a 2-entry skid buffer with valid/ready handshakes on both sides, so decode can stall without a combinational ready path. It sits between the fetch/decode register and the register-read/execute stage; a tag field carries PC or other decode context alongside the immediate.

---
 rtl/imm_gen_pipe.sv | 155 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Decode-stage immediate generator with a 2-entry skid buffer on the output.
// Every RISC-V base immediate format (I, S, B, U, J) is sign-extended to XLEN.
// Define IMMGEN_CSR_ZIMM_EN to enable the CSR zero-extended uimm format (Z, code 101).
// Without that macro, code 101 is treated as illegal.
//
// Parameters:
//   XLEN   output immediate width (32 or 64)
//   TAG_W  sideband tag width (>= 1)
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake; in_ready is driven from a register only
//   in_inst, in_imm_src    instruction word and immediate format select
//   in_tag                 sideband context, passed through unchanged
//   flush                  synchronous kill of both buffered entries
//   out_valid/out_ready    downstream handshake
//   out_imm, out_tag       generated immediate and its tag
//   out_illegal            format select was unsupported for this entry
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;
  localparam logic [2:0] SRC_Z = 3'b101;

  // Builds a 32-bit immediate first. Bit 31 always equals the sign for
  // I/S/B/U/J and is 0 for Z, so widening to XLEN is a plain sign extension.
  // Returns {illegal, imm}.
  function automatic logic [XLEN:0] gen_imm(input logic [31:0] inst,
                                            input logic [2:0]  src);
    logic [31:0] t;
    logic        ill;
    t   = {{20{inst[31]}}, inst[31:20]};
    ill = 1'b0;
    case (src)
      SRC_I: t = {{20{inst[31]}}, inst[31:20]};
      SRC_S: t = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      SRC_B: t = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      SRC_U: t = {inst[31:12], 12'h000};
      SRC_J: t = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`ifdef IMMGEN_CSR_ZIMM_EN
      SRC_Z: t = {27'h0000000, inst[19:15]};
`else
      SRC_Z: begin
        t   = {{20{inst[31]}}, inst[31:20]};
        ill = 1'b1;
      end
`endif
      default: begin
        t   = {{20{inst[31]}}, inst[31:20]};
        ill = 1'b1;
      end
    endcase
    return {ill, XLEN'({{32{t[31]}}, t})};
  endfunction

  // Main (output) entry and skid entry
  logic             m_valid_r;
  logic [XLEN-1:0]  m_imm_r;
  logic [TAG_W-1:0] m_tag_r;
  logic             m_ill_r;
  logic             k_valid_r;
  logic [XLEN-1:0]  k_imm_r;
  logic [TAG_W-1:0] k_tag_r;
  logic             k_ill_r;

  logic [XLEN:0]    gen_s;
  logic [XLEN-1:0]  new_imm_s;
  logic             new_ill_s;
  logic             accept_s;
  logic             pop_s;
  logic             unused_opcode_s;

  // The opcode field is never part of any immediate
  assign unused_opcode_s = ^in_inst[6:0];

  // Decode the incoming instruction's immediate
  always_comb begin
    gen_s     = gen_imm(in_inst, in_imm_src);
    new_imm_s = gen_s[XLEN-1:0];
    new_ill_s = gen_s[XLEN];
  end

  // Handshakes; in_ready depends only on the skid valid register
  always_comb begin
    in_ready = ~k_valid_r;
    accept_s = in_valid & ~k_valid_r;
    pop_s    = m_valid_r & out_ready;
  end

  // Skid-buffer state update: flush first, then refill M, else spill into K
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_imm_r   <= '0;
      m_tag_r   <= '0;
      m_ill_r   <= 1'b0;
      k_valid_r <= 1'b0;
      k_imm_r   <= '0;
      k_tag_r   <= '0;
      k_ill_r   <= 1'b0;
    end else if (flush) begin
      m_valid_r <= 1'b0;
      k_valid_r <= 1'b0;
    end else if (!m_valid_r || pop_s) begin
      if (k_valid_r) begin
        // K always holds the older entry, so it moves up before any new one
        m_valid_r <= 1'b1;
        m_imm_r   <= k_imm_r;
        m_tag_r   <= k_tag_r;
        m_ill_r   <= k_ill_r;
        k_valid_r <= 1'b0;
      end else if (accept_s) begin
        m_valid_r <= 1'b1;
        m_imm_r   <= new_imm_s;
        m_tag_r   <= in_tag;
        m_ill_r   <= new_ill_s;
      end else begin
        m_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      k_valid_r <= 1'b1;
      k_imm_r   <= new_imm_s;
      k_tag_r   <= in_tag;
      k_ill_r   <= new_ill_s;
    end else begin
      k_valid_r <= k_valid_r;
    end
  end

  assign out_valid   = m_valid_r;
  assign out_imm     = m_imm_r;
  assign out_tag     = m_tag_r;
  assign out_illegal = m_ill_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
// Self-checking bench for imm_gen_pipe. It instantiates one XLEN=32 copy and one XLEN=64 copy on
// shared inputs. A queue-based reference of the 2-entry FIFO and an arithmetic immediate model
// supply every expected value.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_src;
  logic [31:0] in_tag;
  logic        flush;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32, out_tag32;
  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_imm_src(in_imm_src), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_illegal(out_ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_imm_src(in_imm_src), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  src;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
  } ent_t;

  vec_t tbl [10];
  ent_t q [$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rst_data_chk;

  function automatic longint sext(input longint raw, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    if (raw >= half) return raw - half * 2;
    return raw;
  endfunction

  // Reference immediate: field values assembled arithmetically, returns {illegal, imm64}
  function automatic logic [64:0] ref_imm(input logic [31:0] inst, input logic [2:0] src);
    longint i_imm, v;
    logic   ill;
    i_imm = sext(longint'(inst[31:20]), 12);
    ill   = 1'b0;
    case (src)
      3'd0: v = i_imm;
      3'd1: v = sext(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
      3'd2: v = sext(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
                     longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
      3'd3: v = sext(longint'(inst[31:12]) * 4096, 32);
      3'd4: v = sext(longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096 +
                     longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
`ifdef IMMGEN_CSR_ZIMM_EN
      3'd5: v = longint'(inst[19:15]);
`else
      3'd5: begin v = i_imm; ill = 1'b1; end
`endif
      default: begin v = i_imm; ill = 1'b1; end
    endcase
    return {ill, 64'(v)};
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_now();
    cmp("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    cmp("in_ready32",  64'(in_ready32),  64'(q.size() < 2));
    cmp("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    cmp("in_ready64",  64'(in_ready64),  64'(q.size() < 2));
    if (q.size() > 0) begin
      ent_t e;
      e = q[0];
      cmp("out_imm32",     {32'h0, out_imm32}, {32'h0, e.imm[31:0]});
      cmp("out_tag32",     64'(out_tag32), 64'(e.tag));
      cmp("out_illegal32", 64'(out_ill32), 64'(e.ill));
      cmp("out_imm64",     out_imm64, e.imm);
      cmp("out_tag64",     64'(out_tag64), 64'(e.tag));
      cmp("out_illegal64", 64'(out_ill64), 64'(e.ill));
    end else if (rst_data_chk) begin
      cmp("rst_imm32", {32'h0, out_imm32}, 64'h0);
      cmp("rst_tag32", 64'(out_tag32), 64'h0);
      cmp("rst_ill32", 64'(out_ill32), 64'h0);
      cmp("rst_imm64", out_imm64, 64'h0);
    end
    rst_data_chk = 1'b0;
  endtask

  // One clock: check current outputs, drive inputs, advance the reference at the edge
  task automatic cycle(input bit v, input logic [31:0] inst, input logic [2:0] src,
                       input logic [31:0] tag, input bit fl, input bit ordy,
                       input logic [63:0] e_imm, input bit e_ill);
    bit   acc, pop;
    ent_t e;
    check_now();
    in_valid   = v;
    in_inst    = inst;
    in_imm_src = src;
    in_tag     = tag;
    flush      = fl;
    out_ready  = ordy;
    acc   = v && (q.size() < 2);
    pop   = (q.size() > 0) && ordy;
    e.imm = e_imm;
    e.tag = tag;
    e.ill = e_ill;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic rcycle(input bit v, input logic [31:0] inst, input logic [2:0] src,
                        input logic [31:0] tag, input bit fl, input bit ordy);
    logic [64:0] r;
    r = ref_imm(inst, src);
    cycle(v, inst, src, tag, fl, ordy, r[63:0], r[64]);
  endtask

  initial begin
    tbl[0] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[1] = '{32'hFE20AE23, 3'd1, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[2] = '{32'hFE000CE3, 3'd2, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    tbl[3] = '{32'h123450B7, 3'd3, 64'h0000000012345000, 1'b0};
    tbl[4] = '{32'h800000B7, 3'd3, 64'hFFFFFFFF80000000, 1'b0};
    tbl[5] = '{32'hFF9FF06F, 3'd4, 64'hFFFFFFFFFFFFFFF8, 1'b0};
`ifdef IMMGEN_CSR_ZIMM_EN
    tbl[6] = '{32'h0000D073, 3'd5, 64'h0000000000000001, 1'b0};
`else
    tbl[6] = '{32'h0000D073, 3'd5, 64'h0000000000000000, 1'b1};
`endif
    tbl[7] = '{32'h0000D073, 3'd7, 64'h0000000000000000, 1'b1};
    tbl[8] = '{32'h00A00093, 3'd0, 64'h000000000000000A, 1'b0};
    tbl[9] = '{32'h7FF00093, 3'd6, 64'h00000000000007FF, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_imm_src = 3'd0;
    in_tag = 32'h0; flush = 1'b0; out_ready = 1'b0; rst_data_chk = 1'b1;
    repeat (2) @(negedge clk);
    check_now();
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors back-to-back with out_ready high
    for (int i = 0; i < 10; i++)
      cycle(1'b1, tbl[i].inst, tbl[i].src, 32'h100 + 32'(i), 1'b0, 1'b1, tbl[i].imm, tbl[i].ill);
    rcycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1);

    // Backpressure: three offers while stalled, then drain
    rcycle(1'b1, 32'h00500093, 3'd0, 32'hA1, 1'b0, 1'b0);
    rcycle(1'b1, 32'hFE20AE23, 3'd1, 32'hA2, 1'b0, 1'b0);
    rcycle(1'b1, 32'h123450B7, 3'd3, 32'hA3, 1'b0, 1'b0);
    cmp("bp_in_ready_low", 64'(in_ready32), 64'h0);
    rcycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1);
    cmp("bp_in_ready_back", 64'(in_ready32), 64'h1);
    rcycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1);
    rcycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1);

    // Flush with both entries full and a new offer
    rcycle(1'b1, 32'h00100093, 3'd0, 32'hB1, 1'b0, 1'b0);
    rcycle(1'b1, 32'h00200093, 3'd0, 32'hB2, 1'b0, 1'b0);
    rcycle(1'b1, 32'h00300093, 3'd0, 32'hB3, 1'b1, 1'b1);
    cmp("flush_out_valid", 64'(out_valid32), 64'h0);
    cmp("flush_in_ready",  64'(in_ready32),  64'h1);
    rcycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset with both entries valid
    rcycle(1'b1, 32'hFE000CE3, 3'd2, 32'hC1, 1'b0, 1'b0);
    rcycle(1'b1, 32'h800000B7, 3'd3, 32'hC2, 1'b0, 1'b0);
    check_now();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst_out_valid32", 64'(out_valid32), 64'h0);
    cmp("arst_in_ready32",  64'(in_ready32),  64'h1);
    cmp("arst_out_valid64", 64'(out_valid64), 64'h0);
    cmp("arst_in_ready64",  64'(in_ready64),  64'h1);
    q.delete();
    rst_data_chk = 1'b1;
    @(negedge clk);
    check_now();
    rst_n = 1'b1;
    @(negedge clk);
    rcycle(1'b1, 32'hFFF00093, 3'd0, 32'hD1, 1'b0, 1'b1);
    rcycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1);

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++)
      rcycle(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));
    check_now();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
